// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the control unit's stage-2 memory
// strobes. A single read or write request is accepted in IDLE. The block then
// runs an async-SRAM cycle (SETUP, ACCESS with wait states, HOLD) and stalls
// the pipeline until HOLD, where done pulses for one cycle.
// Optional feature macro: MEM_RESP_EXT_WAIT_EN. It adds the ext_wait_n input
// and the TIMEOUT parameter. Once the wait-state counter expires, ACCESS is
// extended while ext_wait_n is low, for at most TIMEOUT cycles.
module mem_responder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 1
`ifdef MEM_RESP_EXT_WAIT_EN
  ,
  parameter int unsigned TIMEOUT     = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  done,
  output logic                  stall,
  output logic                  err,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [WIDTH-1:0]      sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
`ifdef MEM_RESP_EXT_WAIT_EN
  ,
  input  logic                  ext_wait_n
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       dir_rd;
  logic       req_one, req_both;
  logic       cnt_zero;
  logic       ext_hold, ext_timeout;
  logic       access_done;

  assign req_one     = mem_read ^ mem_write;
  assign req_both    = mem_read & mem_write;
  assign cnt_zero    = (wait_cnt == '0);
  assign access_done = (state == ACCESS) && cnt_zero && !ext_hold;

`ifdef MEM_RESP_EXT_WAIT_EN
  localparam int unsigned ExtW = $clog2(TIMEOUT + 2);
  logic [ExtW-1:0] ext_cnt;

  // Count extension cycles spent in ACCESS after the wait-state counter expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_cnt <= '0;
    end else if (state == IDLE) begin
      ext_cnt <= '0;
    end else if (ext_hold) begin
      ext_cnt <= ext_cnt + 1'b1;
    end
  end
`endif

  // Decide whether the external wait input extends ACCESS or has timed out.
  always_comb begin
    ext_hold    = 1'b0;
    ext_timeout = 1'b0;
`ifdef MEM_RESP_EXT_WAIT_EN
    if ((state == ACCESS) && cnt_zero && !ext_wait_n) begin
      if (ext_cnt == ExtW'(TIMEOUT)) ext_timeout = 1'b1;
      else                           ext_hold    = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS (wait states) -> HOLD -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_one) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes, done and stall, decoded from state and captured direction.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: stall = req_one;
      SETUP: begin
        sram_ce_n = 1'b0;
        stall     = 1'b1;
        if (dir_rd) sram_oe_n  = 1'b0;
        else        sram_dq_oe = 1'b1;
      end
      ACCESS: begin
        sram_ce_n = 1'b0;
        stall     = 1'b1;
        if (dir_rd) begin
          sram_oe_n = 1'b0;
        end else begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
        end
      end
      HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = !dir_rd;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the request on accept, run the wait-state counter and latch read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      dir_rd      <= 1'b0;
      wait_cnt    <= '0;
      rdata       <= '0;
    end else begin
      if ((state == IDLE) && req_one) begin
        sram_addr   <= addr;
        sram_dq_out <= wdata;
        dir_rd      <= mem_read;
        wait_cnt    <= WaitLoad;
      end else if ((state == ACCESS) && !cnt_zero) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (access_done && dir_rd) begin
        rdata <= ext_timeout ? '1 : sram_dq_in;
      end
    end
  end

  // Sticky error: simultaneous requests or wait timeout; a new error beats err_clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (((state == IDLE) && req_both) || ext_timeout) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (WAIT_STATES=1 and 0), each with its own
// SRAM model. A scoreboard queue per instance holds the expected completion
// cycle, data and strobe counts. These are popped when done pulses.
module tb_mem_responder;

  localparam int TB_TIMEOUT = 4;

  typedef struct {
    bit          rd;
    logic [15:0] a;
    logic [7:0]  d;
    int          due;
    int          we_lo;
    int          oe_lo;
    int          st_hi;
    bit          err_e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        err_clr;
  logic        rd      [2];
  logic        wr      [2];
  logic [15:0] addr    [2];
  logic [7:0]  wdata   [2];
  logic [7:0]  rdata   [2];
  logic        done    [2];
  logic        stall   [2];
  logic        err     [2];
  logic [15:0] s_addr  [2];
  logic [7:0]  dq_out  [2];
  logic        dq_oe   [2];
  logic [7:0]  dq_in   [2];
  logic        ce_n    [2];
  logic        oe_n    [2];
  logic        we_n    [2];
`ifdef MEM_RESP_EXT_WAIT_EN
  logic        ext_n   [2];
`endif

  logic [7:0]  mem     [2][65536];
  logic [7:0]  ref_mem [2][65536];
  exp_t        sb      [2][$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_c[2], oe_c[2], st_c[2], starts[2], exp_starts[2];
  logic        prev_ce[2];

  always #5 clk = ~clk;

  mem_responder #(
    .WIDTH(8), .ADDR_WIDTH(16), .WAIT_STATES(1)
`ifdef MEM_RESP_EXT_WAIT_EN
    , .TIMEOUT(TB_TIMEOUT)
`endif
  ) u_w1 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .done(done[0]),
    .stall(stall[0]), .err(err[0]), .err_clr(err_clr), .sram_addr(s_addr[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0])
`ifdef MEM_RESP_EXT_WAIT_EN
    , .ext_wait_n(ext_n[0])
`endif
  );

  mem_responder #(
    .WIDTH(8), .ADDR_WIDTH(16), .WAIT_STATES(0)
`ifdef MEM_RESP_EXT_WAIT_EN
    , .TIMEOUT(TB_TIMEOUT)
`endif
  ) u_w0 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .done(done[1]),
    .stall(stall[1]), .err(err[1]), .err_clr(err_clr), .sram_addr(s_addr[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1])
`ifdef MEM_RESP_EXT_WAIT_EN
    , .ext_wait_n(ext_n[1])
`endif
  );

  // SRAM read path: data only while selected and output-enabled.
  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][s_addr[0]] : 8'h00;
  assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][s_addr[1]] : 8'h00;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int wst(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter and SRAM write model.
  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 65536; a++) mem[i][a] = init_val(16'(a));
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++)
        if (!ce_n[i] && !we_n[i] && dq_oe[i]) mem[i][s_addr[i]] = dq_out[i];
    end
  end

  // Monitor: strobe counters per access and scoreboard pop on done.
  initial begin
    for (int i = 0; i < 2; i++) begin
      we_c[i] = 0; oe_c[i] = 0; st_c[i] = 0; starts[i] = 0; prev_ce[i] = 1'b1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          we_c[i] = 0; oe_c[i] = 0; st_c[i] = 0; prev_ce[i] = 1'b1;
        end else begin
          if (!we_n[i]) we_c[i]++;
          if (!oe_n[i]) oe_c[i]++;
          if (!ce_n[i] && stall[i]) st_c[i]++;
          if (!ce_n[i] && prev_ce[i]) starts[i]++;
          prev_ce[i] = ce_n[i];
          if (done[i]) begin
            if (sb[i].size() == 0) begin
              check("unexpected_done", 32'(i), 32'hFFFF_FFFF);
            end else begin
              exp_t e;
              e = sb[i].pop_front();
              check("done_cycle", 32'(cyc), 32'(e.due));
              check("we_low_cycles", 32'(we_c[i]), 32'(e.we_lo));
              check("oe_low_cycles", 32'(oe_c[i]), 32'(e.oe_lo));
              check("stall_cycles", 32'(st_c[i]), 32'(e.st_hi));
              check("hold_stall", 32'(stall[i]), 32'd0);
              check("hold_dq_oe", 32'(dq_oe[i]), 32'(!e.rd));
              check("err_at_done", 32'(err[i]), 32'(e.err_e));
              if (e.rd) check("rdata", 32'(rdata[i]), 32'(e.d));
              else      check("sram_content", 32'(mem[i][e.a]), 32'(e.d));
            end
            we_c[i] = 0; oe_c[i] = 0; st_c[i] = 0;
          end
        end
      end
    end
  end

  // One request on instance i; ext_k = extension cycles requested via ext_wait_n.
  task automatic req(input int i, input bit is_rd, input logic [15:0] a,
                     input logic [7:0] d, input int ext_k);
    exp_t e;
    int   c0;
    int   w;
    int   ext;
    bit   seen;
    w   = wst(i);
    ext = (ext_k > TB_TIMEOUT) ? TB_TIMEOUT : ext_k;
    @(negedge clk);
    c0       = cyc;
    rd[i]    = is_rd;
    wr[i]    = !is_rd;
    addr[i]  = a;
    wdata[i] = d;
`ifdef MEM_RESP_EXT_WAIT_EN
    if (ext_k > 0) ext_n[i] = 1'b0;
`endif
    e.rd    = is_rd;
    e.a     = a;
    e.due   = c0 + w + 3 + ext;
    e.we_lo = is_rd ? 0 : w + 1 + ext;
    e.oe_lo = is_rd ? w + 2 + ext : 0;
    e.st_hi = w + 2 + ext;
    e.err_e = (ext_k > TB_TIMEOUT);
    if (is_rd) begin
      e.d = (ext_k > TB_TIMEOUT) ? 8'hFF : ref_mem[i][a];
    end else begin
      e.d = d;
      ref_mem[i][a] = d;
    end
    sb[i].push_back(e);
    exp_starts[i]++;
    #1 check("req_stall", 32'(stall[i]), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
`ifdef MEM_RESP_EXT_WAIT_EN
      if (cyc == c0 + w + 2 + ext_k) ext_n[i] = 1'b1;
`endif
      if (done[i]) seen = 1'b1;
    end
    if (!seen) check("done_wait_expired", 32'd0, 32'd1);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
`ifdef MEM_RESP_EXT_WAIT_EN
    ext_n[i] = 1'b1;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [7:0]  rdat;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 65536; a++) ref_mem[i][a] = init_val(16'(a));
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; exp_starts[i] = 0;
`ifdef MEM_RESP_EXT_WAIT_EN
      ext_n[i] = 1'b1;
`endif
    end
    err_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ce_n", 32'(ce_n[i]), 32'd1);
      check("rst_oe_n", 32'(oe_n[i]), 32'd1);
      check("rst_we_n", 32'(we_n[i]), 32'd1);
      check("rst_dq_oe", 32'(dq_oe[i]), 32'd0);
      check("rst_rdata", 32'(rdata[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
      check("rst_err", 32'(err[i]), 32'd0);
      check("rst_sram_addr", 32'(s_addr[i]), 32'd0);
      check("rst_stall", 32'(stall[i]), 32'd0);
    end
    reset_n = 1'b1;

    // W=1 write then read back.
    req(0, 1'b0, 16'h1234, 8'hA5, 0);
    req(0, 1'b1, 16'h1234, 8'h00, 0);

    // W=0 back-to-back, including the top address.
    req(1, 1'b1, 16'h0000, 8'h00, 0);
    req(1, 1'b0, 16'hFFFF, 8'h3C, 0);
    req(1, 1'b1, 16'hFFFF, 8'h00, 0);
    check("t3_no_wrap", 32'(mem[1][0]), 32'(init_val(16'h0000)));

    // Random write/read pairs on both instances.
    for (int n = 0; n < 6; n++) begin
      ra   = 16'($urandom);
      rdat = 8'($urandom);
      req(n % 2, 1'b0, ra, rdat, 0);
      req(n % 2, 1'b1, ra, 8'h00, 0);
    end

    // Simultaneous requests: no access, err set, stall low; set beats clear.
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1;
    #1 check("t4_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    check("t4_err_set", 32'(err[0]), 32'd1);
    check("t4_ce_n", 32'(ce_n[0]), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    check("t4_set_wins", 32'(err[0]), 32'd1);
    check("t4_ce_n2", 32'(ce_n[0]), 32'd1);
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(negedge clk);
    check("t4_err_clr", 32'(err[0]), 32'd0);
    err_clr = 1'b0;

    // Reset during write ACCESS (same data as already stored at 0x1234).
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 16'h1234; wdata[0] = 8'hA5;
    exp_starts[0]++;
    @(negedge clk);
    @(negedge clk);
    check("t5_we_active", 32'(we_n[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_we_n", 32'(we_n[0]), 32'd1);
    check("t5_ce_n", 32'(ce_n[0]), 32'd1);
    check("t5_dq_oe", 32'(dq_oe[0]), 32'd0);
    check("t5_done", 32'(done[0]), 32'd0);
    wr[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5_no_done", 32'(done[0]), 32'd0);
    end
    reset_n = 1'b1;
    req(0, 1'b1, 16'h1234, 8'h00, 0);

`ifdef MEM_RESP_EXT_WAIT_EN
    // External wait: released after 2 cycles, then held to timeout.
    req(0, 1'b1, 16'h1234, 8'h00, 2);
    req(0, 1'b1, 16'h0042, 8'h00, 1000);
    @(negedge clk);
    check("t6_err_sticky", 32'(err[0]), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t6_err_clr", 32'(err[0]), 32'd0);
`endif

    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("sb_empty", 32'(sb[i].size()), 32'd0);
      check("access_count", 32'(starts[i]), 32'(exp_starts[i]));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
